// File: rtl/sccb_master.sv
// sccb_master: SCCB initiator for camera register writes (3-phase) and reads
// (2-phase write then 2-phase read). The bus timebase is a quarter-bit (qt)
// tick every CLK_DIV clocks, and each bit cell is 4 qt long.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   start, rw, dev_addr, sub_addr,      request, latched when idle
//   wr_data
//   busy, done, rd_data, ack_err        status
//   SIO_C, SIO_D                        bus clock and open data line
// Define SCCB_ACK_CHECK_EN to abort on a high don't-care bit and flag ack_err.
module sccb_master #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] sub_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       ack_err,
  output logic       SIO_C,
  inout  wire        SIO_D
);

  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_TX_BIT, S_TX_X,
    S_RX_BIT, S_RX_NA, S_STOP, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] div_q, div_d;
  logic [1:0]    qt_q, qt_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic          rd_ph_q, rd_ph_d;
  logic          rw_q, rw_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    sub_q, sub_d;
  logic [7:0]    wd_q, wd_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          done_q, done_d;
  logic          scl_q, scl_d;
  logic          sda_oe_q, sda_oe_d;
  logic          sda_o_q, sda_o_d;
  logic          tick, qt_end, cell_c, abort;

`ifdef SCCB_ACK_CHECK_EN
  logic ack_err_q, ack_err_d;
  assign abort = ack_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_err_q <= 1'b0;
    else        ack_err_q <= ack_err_d;
  end
  assign ack_err = ack_err_q;
`else
  assign abort   = 1'b0;
  assign ack_err = 1'b0;
`endif

  assign tick   = (div_q == CW'(CLK_DIV - 1));
  assign qt_end = tick && (qt_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      qt_q      <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      rd_ph_q   <= 1'b0;
      rw_q      <= 1'b0;
      dev_q     <= '0;
      sub_q     <= '0;
      wd_q      <= '0;
      sh_q      <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      sda_o_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qt_q      <= qt_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      rd_ph_q   <= rd_ph_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      sub_q     <= sub_d;
      wd_q      <= wd_d;
      sh_q      <= sh_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      sda_o_q   <= sda_o_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    qt_d      = qt_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    rd_ph_d   = rd_ph_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    sub_d     = sub_q;
    wd_d      = wd_q;
    sh_d      = sh_q;
    rd_data_d = rd_data_q;
    done_d    = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
    ack_err_d = ack_err_q;
    if (state_q == S_TX_X && tick && qt_q == 2'd2 && SIO_D)
      ack_err_d = 1'b1;
`endif
    if (state_q != S_IDLE) begin
      div_d = tick ? '0 : div_q + CW'(1);
      if (tick) qt_d = qt_q + 2'd1;
    end
    unique case (state_q)
      S_IDLE: begin
        div_d = '0;
        qt_d  = '0;
        if (start) begin
          state_d = S_START;
          rw_d    = rw;
          dev_d   = dev_addr;
          sub_d   = sub_addr;
          wd_d    = wr_data;
          rd_ph_d = 1'b0;
          byte_d  = '0;
          bit_d   = '0;
`ifdef SCCB_ACK_CHECK_EN
          ack_err_d = 1'b0;
`endif
        end
      end
      S_START: if (qt_end) begin
        state_d = S_TX_BIT;
        sh_d    = {dev_q, rd_ph_q};
      end
      S_TX_BIT: if (qt_end) begin
        sh_d  = {sh_q[6:0], 1'b0};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_TX_X;
      end
      S_TX_X: if (qt_end) begin
        byte_d = byte_q + 2'd1;
        if (abort) begin
          state_d = S_STOP;
        end else if (rd_ph_q) begin
          state_d = S_RX_BIT;
        end else if (byte_q == 2'd0) begin
          state_d = S_TX_BIT;
          sh_d    = sub_q;
        end else if (byte_q == 2'd1 && !rw_q) begin
          state_d = S_TX_BIT;
          sh_d    = wd_q;
        end else begin
          state_d = S_STOP;
        end
      end
      S_RX_BIT: begin
        if (tick && qt_q == 2'd2) sh_d = {sh_q[6:0], SIO_D};
        if (qt_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_RX_NA;
        end
      end
      S_RX_NA: if (qt_end) state_d = S_STOP;
      S_STOP: if (qt_end) begin
        // first STOP of a read is followed by the gap and a repeated START
        if (rw_q && !rd_ph_q && !abort) begin
          state_d = S_GAP;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (rd_ph_q && !abort) rd_data_d = sh_q;
        end
      end
      S_GAP: if (qt_end) begin
        state_d = S_START;
        rd_ph_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // bus pins decoded from next state so they leave glitch-free flops
  assign cell_c = (qt_d == 2'd1) || (qt_d == 2'd2);

  always_comb begin
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    sda_o_d  = 1'b1;
    unique case (state_d)
      S_START: begin
        scl_d    = (qt_d != 2'd3);
        sda_oe_d = 1'b1;
        sda_o_d  = (qt_d == 2'd0);
      end
      S_TX_BIT: begin
        scl_d    = cell_c;
        sda_oe_d = 1'b1;
        sda_o_d  = sh_d[7];
      end
      S_TX_X, S_RX_BIT: scl_d = cell_c;
      S_RX_NA: begin
        scl_d    = cell_c;
        sda_oe_d = 1'b1;
      end
      S_STOP: begin
        scl_d    = (qt_d != 2'd0);
        sda_oe_d = (qt_d != 2'd3);
        sda_o_d  = (qt_d == 2'd2);
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign rd_data = rd_data_q;
  assign SIO_C   = scl_q;
  assign SIO_D   = sda_oe_q ? sda_o_q : 1'bz;

endmodule

// File: tb/tb_sccb_master.sv
// tb_sccb_master: random SCCB transactions against a token-level bus model
// with a reactive slave that acks, nacks and returns read data.
module tb_sccb_master;

  localparam int CDIV = 4;
  localparam int LIM  = 200 * CDIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] sub_addr = '0;
  logic [7:0] wr_data = '0;
  logic       busy, done, ack_err, sio_c;
  logic [7:0] rd_data;
  wire        sio_d;

  logic slv_en = 1'b0;
  logic slv_val = 1'b1;
  pullup (sio_d);
  assign sio_d = slv_en ? slv_val : 1'bz;

  sccb_master #(.CLK_DIV(CDIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw),
    .dev_addr(dev_addr), .sub_addr(sub_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .rd_data(rd_data), .ack_err(ack_err),
    .SIO_C(sio_c), .SIO_D(sio_d)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // bus monitor: -1 START, -2 STOP, else {byte, ninth bit}
  int         tok_q[$];
  int         mbits = 0, mbyte = 0;
  bit         mrd = 0;
  logic [8:0] msh = '0;
  bit         pc = 1, pd = 1;

  initial forever begin
    @(sio_c or sio_d or rst_n);
    if (!rst_n) begin
      mbits = 0; mbyte = 0; mrd = 0;
    end else if (sio_c && pc && pd && !sio_d) begin
      tok_q.push_back(-1); mbits = 0; mbyte = 0; mrd = 0;
    end else if (sio_c && pc && !pd && sio_d) begin
      tok_q.push_back(-2); mbits = 0;
    end else if (sio_c && !pc) begin
      msh = {msh[7:0], sio_d};
      mbits++;
      if (mbits == 9) begin
        tok_q.push_back(int'(msh));
        if (mbyte == 0) mrd = msh[1];
        mbyte++;
        mbits = 0;
      end
    end
    pc = sio_c;
    pd = sio_d;
  end

  // slave: drives the ninth bit of written bytes and the read byte
  int         base = 0;
  int         slv_nk = 3;
  int         slv_gen = 0;
  logic [7:0] slv_rd = '0;

  function automatic int wr_cnt();
    int c = 0;
    for (int i = base; i < tok_q.size(); i++)
      if (tok_q[i] >= 0) c++;
    return c;
  endfunction

  initial begin
    bit drv, v;
    int g;
    forever begin
      @(negedge sio_c or negedge rst_n);
      slv_en = 1'b0;
      if (rst_n) begin
        g = slv_gen; drv = 0; v = 1;
        if (mbits == 8 && !(mbyte == 1 && mrd)) begin
          drv = 1; v = (wr_cnt() == slv_nk);
        end else if (mbyte == 1 && mrd && mbits < 8) begin
          drv = 1; v = slv_rd[7 - mbits];
        end
        if (drv) begin
          repeat (CDIV) @(posedge clk);
          #1;
          if (g == slv_gen) begin
            slv_val = v; slv_en = 1'b1;
          end
        end
      end
    end
  end

  int t_rise = 0, t_per = 0, t_hi = 0, done_cnt = 0;
  initial forever begin
    @(posedge sio_c);
    t_per = int'($time) - t_rise;
    t_rise = int'($time);
  end
  initial forever begin
    @(negedge sio_c);
    t_hi = int'($time) - t_rise;
  end
  initial forever begin
    @(posedge done);
    done_cnt++;
  end

  logic [7:0] exp_rd = '0;
  bit abort_en;

  task automatic txn(input bit rw_i, input logic [6:0] dv,
                     input logic [7:0] sa, input logic [7:0] wd,
                     input logic [7:0] rb, input int nk,
                     input bit repulse, input bit hold, input bit pre);
    int eq[$];
    logic [7:0] wb[3];
    int cyc, nd0, n, ns, nb, np, qt;
    bit ab, got;
    // expected bus tokens from the protocol rules
    wb[0] = {dv, 1'b0}; wb[1] = sa; wb[2] = wd;
    n = rw_i ? 2 : 3;
    ab = 0;
    eq.push_back(-1);
    for (int i = 0; i < n; i++) begin
      eq.push_back(int'({wb[i], (i == nk)}));
      if (i == nk && abort_en) begin ab = 1; break; end
    end
    eq.push_back(-2);
    if (rw_i && !ab) begin
      eq.push_back(-1);
      eq.push_back(int'({dv, 1'b1, (nk == 2)}));
      if (nk == 2 && abort_en) ab = 1;
      else eq.push_back(int'({rb, 1'b1}));
      eq.push_back(-2);
    end
    ns = 0; nb = 0; np = 0;
    foreach (eq[i]) begin
      if (eq[i] == -1) ns++;
      else if (eq[i] == -2) np++;
      else nb++;
    end
    qt = 4 * ns + 36 * nb + 4 * np + 4 * (ns - 1);
    if (rw_i && !ab) exp_rd = rb;

    slv_rd = rb; slv_nk = nk;
    base = tok_q.size();
    nd0 = done_cnt;
    if (!pre) begin
      @(negedge clk);
      rw = rw_i; dev_addr = dv; sub_addr = sa; wr_data = wd;
      start = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("busy_acc", busy, 1);
    chk("err_clr", ack_err, 0);
    if (!hold) begin
      start = 1'b0;
      rw = 1'($urandom); dev_addr = 7'($urandom);
      sub_addr = 8'($urandom); wr_data = 8'($urandom);
    end
    cyc = 0; got = 0;
    while (!got && cyc < LIM) begin
      @(posedge clk);
      cyc++;
      #1;
      if (repulse && cyc == 100) begin
        start = 1'b1; rw = 1'($urandom); dev_addr = 7'($urandom);
      end else if (repulse && cyc == 101) begin
        start = 1'b0;
      end
      if (done) got = 1;
    end
    chk("done_cyc", cyc, qt * CDIV);
    chk("busy_done", busy, 0);
    chk("tok_n", tok_q.size() - base, eq.size());
    for (int i = 0; i < eq.size() && base + i < tok_q.size(); i++)
      chk($sformatf("tok%0d", i), tok_q[base + i], eq[i]);
    chk("rd_data", rd_data, exp_rd);
    chk("ack_err", ack_err, ab);
    chk("scl_per", t_per, 40 * CDIV);
    chk("scl_hi", t_hi, 20 * CDIV);
    if (!hold) begin
      repeat (repulse ? 150 : 3) @(posedge clk);
      #1;
      chk("one_done", done_cnt - nd0, 1);
      chk("idle", busy, 0);
    end
  endtask

  initial begin
    int k;
    bit r;
`ifdef SCCB_ACK_CHECK_EN
    abort_en = 1;
`else
    abort_en = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", sio_c, 1);
    chk("rst_sda", sio_d, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_err", ack_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    txn(0, 7'h21, 8'h12, 8'h80, 8'h00, 3, 0, 0, 0);
    txn(1, 7'h21, 8'h0A, 8'h00, 8'h56, 3, 0, 0, 0);
    txn(0, 7'h3C, 8'h55, 8'hA5, 8'h00, 3, 1, 0, 0);
    txn(1, 7'h42, 8'h01, 8'h00, 8'hC3, 3, 0, 1, 0);
    txn(1, 7'h42, 8'h01, 8'h00, 8'hC3, 3, 0, 0, 1);

    // reset in the middle of the sub-address byte
    @(negedge clk);
    rw = 0; dev_addr = 7'h11; sub_addr = 8'hFF; wr_data = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (50 * CDIV) @(posedge clk);
    #1;
    rst_n = 1'b0;
    slv_gen++;
    #1;
    chk("mid_scl", sio_c, 1);
    chk("mid_sda", sio_d, 1);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_rd", rd_data, 0);
    exp_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    txn(0, 7'h21, 8'h34, 8'h9E, 8'h00, 3, 0, 0, 0);

    txn(0, 7'h21, 8'h12, 8'h80, 8'h00, 0, 0, 0, 0);
    txn(0, 7'h5A, 8'h77, 8'h01, 8'h00, 3, 0, 0, 0);

    repeat (12) begin
      r = 1'($urandom);
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 3;
      txn(r, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
          k, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
